fare_collector: RTL and testbench

FARE_COLLECTOR -- requirements
Module: fare_collector

---
 rtl/fare_collector.sv | 130 +++++++++++++
 tb/tb_fare_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fare_collector.sv
// Coin-operated fare collector: accumulates 5c/10c/25c coins and pulses the turnstile
// once FARE is reached. Excess credit and cancelled credit are returned as change.
module fare_collector #(
  parameter int unsigned FARE = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  input  logic        cancel,
  input  logic        push,
  output logic        coin_pulse,
  output logic [6:0]  credit,
  output logic        change_valid,
  output logic [6:0]  change_amount,
  output logic        reject,
  output logic [15:0] fares_granted
);

  typedef enum logic [1:0] {StIdle, StCollect, StWaitPass} state_e;

  localparam logic [7:0] FareC = 8'(FARE);

  state_e      state_q, state_d;
  logic        coin_pulse_q, coin_pulse_d;
  logic [6:0]  credit_q, credit_d;
  logic        change_valid_q, change_valid_d;
  logic [6:0]  change_amount_q, change_amount_d;
  logic        reject_q, reject_d;
  logic [15:0] fares_q, fares_d;

  logic [7:0] coin_value;
  logic [7:0] sum;
  logic [7:0] excess;
  logic       coin_ok, accepting, paid, refund;

  always_comb begin
    case (coin_type)
      2'b00:   coin_value = 8'd5;
      2'b01:   coin_value = 8'd10;
      2'b10:   coin_value = 8'd25;
      default: coin_value = 8'd0;
    endcase
  end

  // Sums are kept at 8 bits; the largest possible value (FARE - 5 + 25) still fits in 7.
  assign sum       = {1'b0, credit_q} + coin_value;
  assign excess    = sum - FareC;
  assign coin_ok   = coin_valid && (coin_type != 2'b11);
  assign accepting = (state_q != StWaitPass) && !cancel && coin_ok;
  assign paid      = sum >= FareC;
  assign refund    = (state_q == StCollect) && cancel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StCollect: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (coin_ok) begin
          state_d = paid ? StWaitPass : StCollect;
        end
      end
      StWaitPass: begin
        if (push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    coin_pulse_d    = accepting && paid;
    // Cancel wins over a simultaneous coin, so that coin is handed back.
    reject_d        = coin_valid && ((state_q == StWaitPass) || cancel || (coin_type == 2'b11));
    credit_d        = credit_q;
    change_valid_d  = 1'b0;
    change_amount_d = change_amount_q;
    fares_d         = fares_q;
    if (refund) begin
      credit_d        = 7'd0;
      change_valid_d  = 1'b1;
      change_amount_d = credit_q;
    end else if (accepting) begin
      if (paid) begin
        credit_d = 7'd0;
        if (fares_q != 16'hFFFF) fares_d = fares_q + 16'd1;
        if (excess != 8'd0) begin
          change_valid_d  = 1'b1;
          change_amount_d = excess[6:0];
        end
      end else begin
        credit_d = sum[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coin_pulse_q    <= 1'b0;
      credit_q        <= 7'd0;
      change_valid_q  <= 1'b0;
      change_amount_q <= 7'd0;
      reject_q        <= 1'b0;
      fares_q         <= 16'd0;
    end else begin
      coin_pulse_q    <= coin_pulse_d;
      credit_q        <= credit_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      reject_q        <= reject_d;
      fares_q         <= fares_d;
    end
  end

  assign coin_pulse    = coin_pulse_q;
  assign credit        = credit_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign reject        = reject_q;
  assign fares_granted = fares_q;

endmodule

// File: tb/tb_fare_collector.sv
// Scoreboard bench for fare_collector: a behavioural model queues the expected
// registered outputs for each driven cycle, and they are popped after the edge.
module tb_fare_collector;

  localparam int Fare = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coin_valid;
  logic [1:0]  coin_type;
  logic        cancel;
  logic        push;
  logic        coin_pulse;
  logic [6:0]  credit;
  logic        change_valid;
  logic [6:0]  change_amount;
  logic        reject;
  logic [15:0] fares_granted;

  fare_collector #(.FARE(Fare)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .cancel        (cancel),
    .push          (push),
    .coin_pulse    (coin_pulse),
    .credit        (credit),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .reject        (reject),
    .fares_granted (fares_granted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pulse;
    int credit;
    int cv;
    int ca;
    int rej;
    int fares;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 collect, 2 waiting for passage.
  int m_state = 0;
  int m_credit = 0;
  int m_ca = 0;
  int m_fares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int value_of(input bit [1:0] ct);
    if (ct == 2'd0) return 5;
    if (ct == 2'd1) return 10;
    if (ct == 2'd2) return 25;
    return 0;
  endfunction

  task automatic step(input bit rst, input bit cv, input bit [1:0] ct, input bit can,
                      input bit psh);
    exp_t e;
    exp_t got;
    int s;
    rst_n      = !rst;
    coin_valid = cv;
    coin_type  = ct;
    cancel     = can;
    push       = psh;
    e.pulse = 0;
    e.cv    = 0;
    e.rej   = 0;
    if (rst) begin
      m_state  = 0;
      m_credit = 0;
      m_ca     = 0;
      m_fares  = 0;
    end else if (m_state == 2) begin
      if (cv) e.rej = 1;
      if (psh) m_state = 0;
    end else if (can) begin
      if (cv) e.rej = 1;
      if (m_state == 1) begin
        e.cv     = 1;
        m_ca     = m_credit;
        m_credit = 0;
        m_state  = 0;
      end
    end else if (cv) begin
      if (ct == 2'd3) begin
        e.rej = 1;
      end else begin
        s = m_credit + value_of(ct);
        if (s >= Fare) begin
          e.pulse  = 1;
          m_credit = 0;
          m_state  = 2;
          if (m_fares < 65535) m_fares++;
          if (s - Fare != 0) begin
            e.cv = 1;
            m_ca = s - Fare;
          end
        end else begin
          m_credit = s;
          m_state  = 1;
        end
      end
    end
    e.credit = m_credit;
    e.ca     = m_ca;
    e.fares  = m_fares;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("coin_pulse", 32'(coin_pulse), got.pulse);
    check("credit", 32'(credit), got.credit);
    check("change_valid", 32'(change_valid), got.cv);
    check("change_amount", 32'(change_amount), got.ca);
    check("reject", 32'(reject), got.rej);
    check("fares_granted", 32'(fares_granted), got.fares);
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; cancel = 1'b0; push = 1'b0;
    // Reset with noisy inputs, which must be ignored.
    step(1, 1, 2'd2, 0, 1);
    step(1, 0, 2'd0, 1, 0);

    // Single 25c coin pays exactly; pulse lasts one cycle.
    step(0, 1, 2'd2, 0, 0);
    step(0, 0, 2'd0, 0, 0);
    step(0, 0, 2'd0, 0, 1);

    // Three 10c coins: 10, 20, then paid with 5c change.
    step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 0, 2'd0, 0, 1);

    // 5c, 10c, cancel refunds 15; invalid coin then rejected.
    step(0, 1, 2'd0, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 0, 2'd0, 1, 0);
    step(0, 1, 2'd3, 0, 0);

    // Coin during passage wait is rejected; after push the next coin is taken.
    step(0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd2, 0, 0);
    step(0, 0, 2'd0, 1, 0);
    step(0, 0, 2'd0, 0, 1);
    step(0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd0, 0, 1);

    // Cancel with a coin at credit 10: refund 10, coin rejected.
    step(0, 1, 2'd1, 0, 0);
    step(0, 0, 2'd0, 0, 1);
    step(0, 1, 2'd2, 1, 0);

    // Reset mid-collect drops credit silently.
    step(0, 1, 2'd0, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(1, 0, 2'd0, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 0, 2'd0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
